leitor_apuracao: RTL
====================

# leitor_apuracao

Result readout sequencer for the ballot box. It sits after the per-candidate BCD tally counter chains. When voting closes it snapshots all candidate tallies and determines the winning candidate, excluding the null vote. It then streams every tally digit out over a valid/ready handshake to the display or report logic.

## Interface

Parameters:
- NCAND, 5: number of tally channels (candidates plus null).
- NDIG, 6: BCD digits per tally.
- NULO_IDX, 4: index of the null-vote channel; this channel is never eligible to win.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin readout (driven by the ballot box finish signal); sampled only in IDLE.
- tally  in  NCAND*NDIG*4  packed tallies. Channel i occupies bits [i*NDIG*4 +: NDIG*4]; digit 0 is the least significant nibble.
- out_ready  in  1  consumer accepts the current digit.
- out_valid  out  1  the out_* data fields are valid.
- out_cand  out  3  channel index of the current digit.
- out_pos  out  3  digit position of the current digit (NDIG-1 down to 0).
- out_digit  out  4  BCD digit value.
- out_last  out  1  high on the final digit (channel NCAND-1, position 0).
- busy  out  1  readout in progress.
- done  out  1  one-cycle pulse marking the end of readout.
- winner  out  3  index of the winning channel.
- tie  out  1  the winning count is shared by two or more eligible channels.

## Operation

- States: IDLE, COMPARE, SEND, DONE.
- IDLE:
  - When start=1, capture all tallies into an internal snapshot, clear the compare registers and enter COMPARE.
  - start is ignored in every other state.
- COMPARE:
  - Visits index 0..NCAND-1, one per cycle.
  - NULO_IDX is a no-op cycle.
  - The first eligible index loads best=value, winner=index, tie=0.
  - For each later eligible index: if value>best, set best=value, winner=index, tie=0; if value==best, set tie=1 and keep the lower index as winner.
  - Comparison is unsigned binary on the full NDIG*4-bit word, which is order-preserving for valid BCD.
  - After the last index, go to SEND with cand=0, pos=NDIG-1.
- SEND:
  - out_valid=1; out_digit is the snapshot nibble at (cand, pos).
  - A transfer occurs on a cycle with out_valid&out_ready.
  - On transfer, pos decrements. At pos=0, pos reloads NDIG-1 and cand increments.
  - The transfer with out_last=1 moves the FSM to DONE.
- DONE: done=1 for one cycle, then return to IDLE.
- Snapshot isolation: changes on tally after the start cycle have no effect on the output.
- Digits greater than 9 are passed through unchanged and compared as binary.
- winner and tie are updated during COMPARE, are final on entry to SEND, and hold until the next start or reset.
- All-zero tallies give winner=0, tie=1.

## Timing

- Reset (reset=0 at an edge) forces IDLE from any state. Every output goes to 0 (out_valid, out_cand, out_pos, out_digit, out_last, busy, done, winner, tie) and the snapshot is cleared.
- With start high in cycle 0:
  - COMPARE occupies cycles 1..NCAND.
  - out_valid first rises in cycle NCAND+1.
- busy is high from cycle 1 through the DONE cycle inclusive.
- Handshake:
  - While out_valid=1 and out_ready=0, all out_* fields hold stable.
  - out_valid never drops before a transfer.
  - out_ready may be asserted before out_valid.
- Throughput: with out_ready held at 1, one digit transfers per cycle, so SEND lasts NCAND*NDIG cycles (30 at default).
- With default parameters and out_ready=1: last transfer in cycle 35, done=1 and busy=1 in cycle 36, back in IDLE (busy=0) in cycle 37.
- start asserted in the DONE cycle is ignored. A start in cycle 37 is accepted.

## Test plan

- Basic readout: tallies ch0=000123, ch1=000045, ch2=000999, ch3=000000, ch4=000500; out_ready=1; start in cycle 0.
  - Expect 30 transfers in cycles 6..35, starting cand0 digits 0,0,0,1,2,3.
  - out_last at cand4 pos0.
  - winner=2, tie=0; done in cycle 36.
- Backpressure: same stimulus with out_ready=0 for 3 cycles at the 8th digit, and toggling every cycle afterwards.
  - Digit fields stay stable while stalled; the full 30-digit sequence is intact.
  - done follows the last accepted transfer by one cycle.
- Tie and null exclusion: ch0=000010, ch1=000010, ch2=000003, ch3=000000, ch4=999999.
  - Expect winner=0, tie=1; ch4 never wins.
- BCD carry boundary: ch0=099999, ch3=100000, others 0 → winner=3, tie=0.
  - All zero → winner=0, tie=1.
- Snapshot and start masking: change all tallies and pulse start during SEND.
  - Streamed digits match the start-cycle values; no restart occurs; busy is unaffected.
- Reset mid-operation: assert reset=0 at the 10th transfer.
  - Next cycle: all outputs 0, state IDLE.
  - A new start restarts at cand0 pos5 with freshly captured tallies.

Source files
------------

// File: rtl/leitor_apuracao.sv
// Result readout sequencer: snapshots the per-channel BCD tallies on start, picks the winner
// (null channel excluded) and streams every digit out over a valid/ready handshake.
module leitor_apuracao #(
    parameter int unsigned NCAND    = 5,
    parameter int unsigned NDIG     = 6,
    parameter int unsigned NULO_IDX = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NCAND*NDIG*4-1:0] tally,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [2:0]              out_cand,
    output logic [2:0]              out_pos,
    output logic [3:0]              out_digit,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              winner,
    output logic                    tie
);

    localparam int unsigned W = NDIG * 4;

    typedef enum logic [1:0] {
        StIdle,
        StCompare,
        StSend,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   snap_q [NCAND];
    logic [W-1:0]   snap_d [NCAND];
    logic [2:0]     idx_q, idx_d;
    logic           have_q, have_d;
    logic [W-1:0]   best_q, best_d;
    logic [2:0]     winner_q, winner_d;
    logic           tie_q, tie_d;
    logic [2:0]     cand_q, cand_d;
    logic [2:0]     pos_q, pos_d;

    logic [W-1:0]   cmp_val;
    logic           is_last;
    logic [3:0]     cur_digit;

    assign cmp_val   = snap_q[idx_q];
    assign is_last   = (cand_q == 3'(NCAND - 1)) && (pos_q == 3'd0);
    assign cur_digit = snap_q[cand_q][{pos_q, 2'b00} +: 4];

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        idx_d    = idx_q;
        have_d   = have_q;
        best_d   = best_q;
        winner_d = winner_q;
        tie_d    = tie_q;
        cand_d   = cand_q;
        pos_d    = pos_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    for (int unsigned i = 0; i < NCAND; i++) begin
                        snap_d[i] = tally[i*W +: W];
                    end
                    idx_d    = 3'd0;
                    have_d   = 1'b0;
                    best_d   = '0;
                    winner_d = 3'd0;
                    tie_d    = 1'b0;
                    state_d  = StCompare;
                end
            end

            StCompare: begin
                // Ties keep the earlier (lower) index because only a strictly larger value moves it.
                if (idx_q != 3'(NULO_IDX)) begin
                    if (!have_q || (cmp_val > best_q)) begin
                        best_d   = cmp_val;
                        winner_d = idx_q;
                        tie_d    = 1'b0;
                        have_d   = 1'b1;
                    end else if (cmp_val == best_q) begin
                        tie_d = 1'b1;
                    end
                end
                if (idx_q == 3'(NCAND - 1)) begin
                    cand_d  = 3'd0;
                    pos_d   = 3'(NDIG - 1);
                    state_d = StSend;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end

            StSend: begin
                if (out_ready) begin
                    if (pos_q == 3'd0) begin
                        pos_d  = 3'(NDIG - 1);
                        cand_d = cand_q + 3'd1;
                        if (is_last) begin
                            state_d = StDone;
                        end
                    end else begin
                        pos_d = pos_q - 3'd1;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= StIdle;
            for (int unsigned i = 0; i < NCAND; i++) begin
                snap_q[i] <= '0;
            end
            idx_q    <= 3'd0;
            have_q   <= 1'b0;
            best_q   <= '0;
            winner_q <= 3'd0;
            tie_q    <= 1'b0;
            cand_q   <= 3'd0;
            pos_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            idx_q    <= idx_d;
            have_q   <= have_d;
            best_q   <= best_d;
            winner_q <= winner_d;
            tie_q    <= tie_d;
            cand_q   <= cand_d;
            pos_q    <= pos_d;
        end
    end

    // Data fields are forced to zero outside SEND so idle outputs read as all-zero.
    assign out_valid = (state_q == StSend);
    assign out_cand  = out_valid ? cand_q    : 3'd0;
    assign out_pos   = out_valid ? pos_q     : 3'd0;
    assign out_digit = out_valid ? cur_digit : 4'd0;
    assign out_last  = out_valid && is_last;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign winner    = winner_q;
    assign tie       = tie_q;

endmodule
